// File: rtl/capture_pkg.sv
// Shared types and helpers for the logic-analyzer capture engine.
package capture_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    POST,
    DUMP,
    DONE
  } state_t;

  // Readout sub-phases: set read address, wait one RAM cycle, stream bytes.
  typedef enum logic [1:0] {
    PH_LOAD,
    PH_PRIME,
    PH_SEND
  } dump_phase_t;

  function automatic int unsigned bytes_per_sample(input int unsigned width);
    return (width + BYTE_W - 1) / BYTE_W;
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module capture_ram #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4096,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/capture_core.sv
// Circular pre/post-trigger capture with masked trigger and newest-first byte readout.
// Optional edge-qualified trigger bits: define CAPTURE_EDGE_TRIG_EN.
module capture_core
  import capture_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 8,
  parameter int unsigned DEPTH        = 4096,
  parameter int unsigned CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    arm,
  input  logic                    abort,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] trig_mask,
  input  logic [SAMPLE_WIDTH-1:0] trig_value,
`ifdef CAPTURE_EDGE_TRIG_EN
  input  logic [SAMPLE_WIDTH-1:0] trig_edge,
`endif
  input  logic [CNT_W-1:0]        read_count,
  input  logic [CNT_W-1:0]        delay_count,
  output logic [BYTE_W-1:0]       tx_byte,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    triggered,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned BPS = bytes_per_sample(SAMPLE_WIDTH);
  localparam int unsigned PW  = BPS * BYTE_W;
  localparam int unsigned IW  = (BPS > 1) ? $clog2(BPS) : 1;

  state_t                  state;
  dump_phase_t             phase;
  logic [AW-1:0]           wr_ptr, rd_ptr, raddr_c;
  logic [CNT_W-1:0]        fill, post_cnt, smp_left;
  logic [CNT_W-1:0]        read_cfg, delay_cfg;
  logic [SAMPLE_WIDTH-1:0] mask_cfg, value_cfg;
  logic [SAMPLE_WIDTH-1:0] rdata;
  logic [PW-1:0]           cur, padded_c;
  logic [IW-1:0]           byte_idx;
  logic [CNT_W-1:0]        r_eff_c, n_c;
  logic                    we_c, match_c, last_xfer_c, load_c;

  assign we_c     = sample_valid && !abort && (state == ARMED || state == POST);
  assign padded_c = PW'(rdata);
  assign r_eff_c  = (read_cfg > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : read_cfg;
  assign n_c      = (r_eff_c < fill) ? r_eff_c : fill;

`ifdef CAPTURE_EDGE_TRIG_EN
  logic [SAMPLE_WIDTH-1:0] edge_cfg, prev_sample;
  logic                    prev_valid;
  logic                    edge_ok_c;
  // Edge bits need the previous sample on the opposite level and this one on trig_value.
  assign edge_ok_c = ((((~(sample_in ^ value_cfg)) & (prev_sample ^ value_cfg)) | ~edge_cfg) == '1)
                     && (prev_valid || edge_cfg == '0);
  assign match_c   = (((sample_in ^ value_cfg) & mask_cfg) == '0) && edge_ok_c;
`else
  assign match_c   = ((sample_in ^ value_cfg) & mask_cfg) == '0;
`endif

  assign last_xfer_c = tx_valid && tx_ready && (byte_idx == IW'(BPS - 1));
  assign load_c      = (state == DUMP) &&
                       ((phase == PH_PRIME) ||
                        (phase == PH_SEND && last_xfer_c && smp_left != '0));

  // Read address runs one step ahead so rdata always holds mem[rd_ptr].
  always_comb begin
    raddr_c = rd_ptr;
    if (state == DUMP && phase == PH_LOAD) raddr_c = wr_ptr - AW'(1);
    else if (load_c)                       raddr_c = rd_ptr - AW'(1);
  end

  capture_ram #(
    .WIDTH(SAMPLE_WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clock(clock),
    .we   (we_c),
    .waddr(wr_ptr),
    .wdata(sample_in),
    .raddr(raddr_c),
    .rdata(rdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      phase     <= PH_LOAD;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      post_cnt  <= '0;
      smp_left  <= '0;
      read_cfg  <= '0;
      delay_cfg <= '0;
      mask_cfg  <= '0;
      value_cfg <= '0;
      cur       <= '0;
      byte_idx  <= '0;
      tx_byte   <= '0;
      tx_valid  <= 1'b0;
      triggered <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef CAPTURE_EDGE_TRIG_EN
      edge_cfg    <= '0;
      prev_sample <= '0;
      prev_valid  <= 1'b0;
`endif
    end else begin
      rd_ptr <= raddr_c;
      done   <= 1'b0;
      if (we_c) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (fill != CNT_W'(DEPTH)) fill <= fill + CNT_W'(1);
      end
      if (abort) begin
        state    <= IDLE;
        phase    <= PH_LOAD;
        tx_valid <= 1'b0;
        busy     <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (arm) begin
            state     <= ARMED;
            busy      <= 1'b1;
            fill      <= '0;
            triggered <= 1'b0;
            mask_cfg  <= trig_mask;
            value_cfg <= trig_value;
            read_cfg  <= read_count;
            delay_cfg <= delay_count;
`ifdef CAPTURE_EDGE_TRIG_EN
            edge_cfg   <= trig_edge;
            prev_valid <= 1'b0;
`endif
          end
          ARMED: if (sample_valid) begin
`ifdef CAPTURE_EDGE_TRIG_EN
            prev_sample <= sample_in;
            prev_valid  <= 1'b1;
`endif
            if (match_c) begin
              triggered <= 1'b1;
              post_cnt  <= delay_cfg;
              phase     <= PH_LOAD;
              state     <= (delay_cfg == '0) ? DUMP : POST;
            end
          end
          POST: if (sample_valid) begin
            post_cnt <= post_cnt - CNT_W'(1);
            if (post_cnt == CNT_W'(1)) state <= DUMP;
          end
          DUMP: begin
            unique case (phase)
              PH_LOAD: begin
                if (n_c == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
                end else begin
                  smp_left <= n_c;
                  phase    <= PH_PRIME;
                end
              end
              default: begin
                if (load_c) begin
                  tx_byte  <= padded_c[BYTE_W-1:0];
                  cur      <= padded_c >> BYTE_W;
                  byte_idx <= '0;
                  tx_valid <= 1'b1;
                  smp_left <= smp_left - CNT_W'(1);
                  phase    <= PH_SEND;
                end else if (last_xfer_c) begin
                  tx_valid <= 1'b0;
                  state    <= DONE;
                  done     <= 1'b1;
                end else if (tx_valid && tx_ready) begin
                  tx_byte  <= cur[BYTE_W-1:0];
                  cur      <= cur >> BYTE_W;
                  byte_idx <= byte_idx + IW'(1);
                end
              end
            endcase
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_core.sv
// Directed bench for capture_core: an 8-bit and a 12-bit instance, both DEPTH=16.
module tb_capture_core;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        arm = 1'b0, abort = 1'b0, sample_valid = 1'b0, tx_ready = 1'b0, sel12 = 1'b0;
  logic [11:0] sample_in = '0, trig_mask = '0, trig_value = '0, trig_edge = '0;
  logic [4:0]  read_count = '0, delay_count = '0;

  logic [7:0]  tx_byte8, tx_byte12, tx_byte;
  logic        tx_valid8, tx_valid12, tx_valid;
  logic        triggered8, triggered12, triggered;
  logic        busy8, busy12, busy;
  logic        done8, done12, done;
  logic        arm8, arm12, ready8, ready12;

  assign arm8      = arm && !sel12;
  assign arm12     = arm && sel12;
  assign ready8    = tx_ready && !sel12;
  assign ready12   = tx_ready && sel12;
  assign tx_byte   = sel12 ? tx_byte12   : tx_byte8;
  assign tx_valid  = sel12 ? tx_valid12  : tx_valid8;
  assign triggered = sel12 ? triggered12 : triggered8;
  assign busy      = sel12 ? busy12      : busy8;
  assign done      = sel12 ? done12      : done8;

  always #5 clock = ~clock;

  capture_core #(.SAMPLE_WIDTH(8), .DEPTH(16)) u_dut8 (
    .clock(clock), .reset_n(reset_n), .arm(arm8), .abort(abort),
    .sample_in(sample_in[7:0]), .sample_valid(sample_valid),
    .trig_mask(trig_mask[7:0]), .trig_value(trig_value[7:0]),
`ifdef CAPTURE_EDGE_TRIG_EN
    .trig_edge(trig_edge[7:0]),
`endif
    .read_count(read_count), .delay_count(delay_count),
    .tx_byte(tx_byte8), .tx_valid(tx_valid8), .tx_ready(ready8),
    .triggered(triggered8), .busy(busy8), .done(done8)
  );

  capture_core #(.SAMPLE_WIDTH(12), .DEPTH(16)) u_dut12 (
    .clock(clock), .reset_n(reset_n), .arm(arm12), .abort(abort),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .trig_mask(trig_mask), .trig_value(trig_value),
`ifdef CAPTURE_EDGE_TRIG_EN
    .trig_edge(trig_edge),
`endif
    .read_count(read_count), .delay_count(delay_count),
    .tx_byte(tx_byte12), .tx_valid(tx_valid12), .tx_ready(ready12),
    .triggered(triggered12), .busy(busy12), .done(done12)
  );

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arm with a config, then scramble the config inputs to prove they were latched.
  task automatic start(input logic [11:0] m, input logic [11:0] v, input int d, input int r);
    @(negedge clock);
    trig_mask = m; trig_value = v; delay_count = 5'(d); read_count = 5'(r); arm = 1'b1;
    @(negedge clock);
    arm = 1'b0; trig_mask = 12'h000; trig_value = 12'hFFF; delay_count = 5'd0; read_count = 5'd1;
    check("arm_busy", 32'(busy), 1);
    check("arm_trig_clr", 32'(triggered), 0);
  endtask

  task automatic feed(input logic [11:0] first, input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      if (gaps) begin
        @(negedge clock);
        sample_valid = 1'b0; sample_in = 12'hFFF;
      end
      @(negedge clock);
      sample_in = first + 12'(i); sample_valid = 1'b1;
    end
    @(negedge clock);
    sample_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int c = 0;
    while (!tx_valid && c < 20) begin
      @(negedge clock);
      c++;
    end
    check(tag, 32'(tx_valid), 1);
  endtask

  // Accept bytes until done; slow=1 asserts tx_ready only one cycle in three.
  task automatic drain(input bit slow);
    bit         got_done = 1'b0;
    bit         hold = 1'b0;
    logic [7:0] held = '0;
    rx_q.delete();
    for (int c = 0; c < 300 && !got_done; c++) begin
      @(negedge clock);
      tx_ready = !slow || (c % 3 == 0);
      if (hold) begin
        check("hold_valid", 32'(tx_valid), 1);
        check("hold_byte", 32'(tx_byte), 32'(held));
      end
      hold = tx_valid && !tx_ready;
      held = tx_byte;
      if (tx_valid && tx_ready) rx_q.push_back(tx_byte);
      if (done) got_done = 1'b1;
    end
    tx_ready = 1'b0;
    check("done_seen", 32'(got_done), 1);
    @(negedge clock);
    check("done_pulse_end", 32'(done), 0);
    check("idle_after_done", 32'(busy), 0);
  endtask

  task automatic check_bytes(input string tag);
    check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clock);
    check("rst_tx_byte", 32'(tx_byte8), 0);
    check("rst_tx_valid", 32'(tx_valid8), 0);
    check("rst_busy", 32'(busy8), 0);
    check("rst_done", 32'(done8), 0);
    check("rst_trig", 32'(triggered8), 0);
    reset_n = 1'b1;
    @(negedge clock);

    // T1: level trigger on bit0, fill clamps the readout to 6 samples
    start(12'h001, 12'h001, 4, 8);
    feed(12'h010, 6, 1'b0);
    check("t1_triggered", 32'(triggered), 1);
    wait_valid("t1_valid");
    check("t1_first_byte", 32'(tx_byte), 32'h15);
    arm = 1'b1;
    @(negedge clock);
    arm = 1'b0;
    check("t1_arm_ignored", 32'(busy), 1);
    drain(1'b0);
    exp_q = '{8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
    check_bytes("t1");
    check("t1_trig_hold", 32'(triggered), 1);

    // T2: mask=0 fires on first sample; extra samples during readout are ignored
    start(12'h000, 12'h000, 3, 3);
    feed(12'h0A0, 6, 1'b0);
    drain(1'b0);
    exp_q = '{8'hA3, 8'hA2, 8'hA1};
    check_bytes("t2");

    // T3: 40 samples with gaps, late trigger, pointer wrap, full-depth readout
    start(12'h0FF, 12'h023, 4, 16);
    feed(12'h000, 40, 1'b1);
    drain(1'b0);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h27 - i));
    check_bytes("t3");

    // T4: 12-bit samples go out LSB byte first with zero-padded top byte
    sel12 = 1'b1;
    start(12'h000, 12'h000, 1, 2);
    feed(12'hABC, 1, 1'b0);
    feed(12'h123, 1, 1'b0);
    drain(1'b0);
    exp_q = '{8'h23, 8'h01, 8'hBC, 8'h0A};
    check_bytes("t4");
    sel12 = 1'b0;

    // T5: throttled tx_ready, read_count above DEPTH saturates
    start(12'h0FF, 12'h005, 2, 31);
    feed(12'h000, 8, 1'b0);
    drain(1'b1);
    exp_q = '{8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
    check_bytes("t5");

    // T6: abort with simultaneous arm mid-readout, then a clean restart
    start(12'h000, 12'h000, 3, 3);
    feed(12'h0C0, 4, 1'b0);
    wait_valid("t6_valid");
    check("t6_byte0", 32'(tx_byte), 32'hC3);
    tx_ready = 1'b1;
    @(negedge clock);
    tx_ready = 1'b0;
    check("t6_byte1", 32'(tx_byte), 32'hC2);
    abort = 1'b1; arm = 1'b1;
    @(negedge clock);
    abort = 1'b0; arm = 1'b0;
    check("t6_abort_busy", 32'(busy), 0);
    check("t6_abort_valid", 32'(tx_valid), 0);
    check("t6_abort_done", 32'(done), 0);
    start(12'h000, 12'h000, 0, 16);
    feed(12'h077, 1, 1'b0);
    drain(1'b0);
    exp_q = '{8'h77};
    check_bytes("t6");
    check("t6_triggered", 32'(triggered), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/capture_core.md
Name: capture_core

Overview:
- Parametrised capture engine for the logic analyzer.
- Replaces the separate sample FIFO, basic trigger and sample counter with one block: a circular pre/post-trigger sample buffer, a masked value trigger, and a newest-first byte readout to the UART transmit path.
- Sits between the sampler output and the transmit mux. The controller drives it through arm/abort and config words.

Parameters:
SAMPLE_WIDTH, 8, channels per sample; 1..32.
DEPTH, 4096, buffer entries; power of two, >=16.
CNT_W, $clog2(DEPTH)+1, width of count ports.

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
arm  in  1  1-cycle pulse; starts capture (honoured in IDLE only)
abort  in  1  1-cycle pulse; returns to IDLE from any state
sample_in  in  SAMPLE_WIDTH  sample from sampler
sample_valid  in  1  sample_in valid this cycle
trig_mask  in  SAMPLE_WIDTH  1 = bit participates in trigger
trig_value  in  SAMPLE_WIDTH  required level of masked bits
read_count  in  CNT_W  samples to return
delay_count  in  CNT_W  samples stored after the trigger sample
tx_byte  out  8  byte to UART
tx_valid  out  1  tx_byte valid
tx_ready  in  1  UART accepts byte (valid&ready = transfer)
triggered  out  1  trigger has fired in current run
busy  out  1  state != IDLE
done  out  1  1-cycle pulse at end of readout

Behaviour:
- Reset: IDLE; tx_byte=0, tx_valid=0, triggered=0, busy=0, done=0; pointers and counters=0. RAM contents are not cleared.
- Config latch: trig_mask, trig_value, read_count and delay_count are registered on the accepted arm. Later changes have no effect until the next arm.
- Effective read count R = min(read_count, DEPTH). Larger values saturate to DEPTH.
- States:
  - IDLE: on arm go to ARMED; clear fill, triggered.
  - ARMED: each sample_valid writes RAM[wr_ptr], wr_ptr++ (wraps mod DEPTH), fill saturates at DEPTH. Match = ((sample_in ^ trig_value) & trig_mask) == 0, evaluated on the same sample. On match: sample is written, triggered=1 next cycle, post counter = delay_count, go to POST. mask=0 triggers on the first valid sample.
  - POST: each sample_valid writes and decrements post counter. At 0 (or on entry if delay_count=0), go to DUMP. Samples with sample_valid=0 are ignored.
  - DUMP:
    - Total samples N = min(R, fill); if N=0, go straight to DONE.
    - rd_ptr starts at wr_ptr-1 (newest) and decrements mod DEPTH. Synchronous RAM read, 1-cycle latency.
    - Each sample is sent as BPS=ceil(SAMPLE_WIDTH/8) bytes, LSB byte first. The top byte is zero-padded.
    - tx_valid stays high and tx_byte stable until tx_ready; the next byte may present the cycle after the transfer. Throughput is one byte per cycle when tx_ready is held high.
    - After N*BPS transfers, go to DONE.
  - DONE: done=1 for one cycle, then IDLE. triggered holds until the next arm.
- Boundaries:
  - abort has priority over every event, including a simultaneous arm. Next cycle: IDLE, tx_valid=0 (a pending byte is dropped).
  - arm outside IDLE is ignored.
  - Writes in POST may overwrite the oldest pre-trigger data; fill saturates.
  - sample_valid is ignored in IDLE, DUMP and DONE.
  - Async reset mid-run behaves as abort plus register reset.

Optional Feature:
- Macro CAPTURE_EDGE_TRIG_EN.
- Defined: adds input trig_edge (SAMPLE_WIDTH, latched at arm). For bits with trig_edge=1, a match additionally requires a change from the previous valid sample: rising when trig_value=1, falling when 0. The previous sample is the last valid sample seen in ARMED; the first sample after arm cannot satisfy an edge bit.
- Undefined: port absent; level-only matching as above.

Decomposition:
- capture_pkg:
  - state enum (IDLE, ARMED, POST, DUMP, DONE)
  - function bytes_per_sample(width)
  - localparam for byte width 8
- Sub-module capture_ram: simple dual-port inferred block RAM, one write port and one registered read port, parametrised by width and depth.

Test Plan:
- DEPTH=16, W=8, mask=8'h01 value=8'h01, delay=4, read=8. Feed 0x10,0x11,... (trigger at 0x11). Expect bytes 0x15,0x14,0x13,0x12,0x11,0x10 then stop (fill=6, clamp); done pulse, triggered=1.
- mask=0, delay=3, read=3. Feed 0xA0.. Expect 0xA3,0xA2,0xA1.
- Run 40 samples with trigger late on DEPTH=16, read=16. Expect exactly 16 newest samples newest-first, with correct pointer wrap.
- W=12, sample 0xABC. Expect bytes 0xBC then 0x0A per sample.
- tx_ready toggled 1-of-3 cycles. tx_byte stays stable while tx_valid&!tx_ready; no byte is lost or duplicated.
- abort mid-DUMP together with arm. Expect IDLE next cycle, tx_valid=0, busy=0; a later arm restarts cleanly with fill=0.
